qsn_controller_pipe: RTL and testbench
======================================

Name: qsn_controller_pipe

Overview:
Parametrised, pipelined successor to the fixed length-3 QSN controller. Converts a per-column cyclic shift factor into left-shifter, right-shifter and merge-stage select words for a QSN of arbitrary permutation length Z. Adds valid/ready flow control, a reverse-permutation mode for the variable-to-check return path, tag pass-through and range checking. Sits between the layer scheduler and the qsn_* datapath instances.

Parameters:
PERMUTATION_LENGTH, 7, cyclic permutation length Z; legal range Z >= 2.
SHIFT_W, $clog2(PERMUTATION_LENGTH), width of shift and select words (derived; do not override).
TAG_W, 4, width of the opaque tag carried with each factor.

Ports:
sys_clk  input  1  clock.
rstn  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  shift_factor, in_reverse and in_tag are valid.
in_ready  output  1  block accepts an input this cycle.
shift_factor  input  SHIFT_W  requested cyclic shift s.
in_reverse  input  1  1 selects the inverse permutation.
in_tag  input  TAG_W  opaque tag (column index).
out_valid  output  1  select words are valid.
out_ready  input  1  downstream consumes this cycle.
left_sel  output  SHIFT_W  left-shifter select.
right_sel  output  SHIFT_W  right-shifter select.
merge_sel  output  Z-1  merge mask; bit i set = lane i takes the left-shifter output.
out_tag  output  TAG_W  tag matching the current outputs.
out_err  output  1  current output came from an out-of-range factor.
err_sticky  output  1  sticky range-error flag.
err_clr  input  1  clears err_sticky.

Behaviour:
- Reset (rstn=0, asynchronous): all stage valids 0, out_valid=0, left_sel=right_sel=0, merge_sel=0, out_tag=0, out_err=0, err_sticky=0. Any in-flight data is discarded. First accept is possible in the first cycle after rstn deasserts.
- Handshake: transfer in = in_valid & in_ready; transfer out = out_valid & out_ready. While out_valid=1 and out_ready=0, all outputs hold stable.
- Two-stage elastic pipeline, latency 2 cycles, throughput 1 per cycle.
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en. This is a combinational path from out_ready to in_ready, and it is permitted.
- Stage 1 (register on in transfer):
  - range = (s >= Z).
  - s_eff = 0 if range=1.
  - Otherwise s_eff = (Z - s) mod Z when in_reverse=1, else s_eff = s.
  - Tag, range bit and s_eff are registered.
- Stage 2 (register on s1_en & s1_valid):
  - If s_eff=0: left_sel=0, right_sel=0, merge_sel=0.
  - Otherwise: left_sel=s_eff, right_sel=Z-s_eff, merge_sel=(1<<(Z-s_eff))-1, truncated to Z-1 bits.
  - out_err = range bit; out_tag = stage-1 tag.
- All arithmetic is performed at SHIFT_W+1 bits, then truncated. Outputs are driven directly from flops.
- Error flag:
  - err_sticky sets on the cycle after an in transfer with range=1.
  - err_clr=1 clears err_sticky.
  - If set and clear occur in the same cycle, set wins.
- When Z is a power of two, range can never be 1.
- in_valid=0 creates bubbles. A bubble advances through the pipeline with out_valid=0, and the select outputs retain their last values.

Test Plan:
- Z=7, forward s=2, tag=3 -> two cycles later: out_valid=1, left_sel=2, right_sel=5, merge_sel=6'b011111, out_tag=3, out_err=0.
- Z=7, in_reverse=1, s=2 -> left_sel=5, right_sel=2, merge_sel=6'b000011. Also check s=0 with either mode -> all selects 0.
- Z=7, s=7 -> out_err=1, all selects 0, err_sticky=1 one cycle after accept. Pulse err_clr while a second s=7 is accepted in the same cycle -> err_sticky stays 1. Pulse err_clr alone -> err_sticky goes to 0.
- Back-to-back stream of s=1..6 with out_ready held low for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs hold stable, no loss or duplication, and the order is preserved by tag.
- Assert rstn low while two items are in flight -> outputs go to reset values immediately, no stale item appears afterwards, and in_ready=1 one cycle after release.
- Z=3 instance sweep of s=0,1,2 -> merge_sel = 00, 11, 01; right_sel = 0, 2, 1. This matches the legacy length-3 controller.

Source files
------------

// File: rtl/qsn_controller_pipe.sv
// Turns a per-column cyclic shift factor into QSN left/right/merge select words.
// Two-stage elastic pipeline with reverse-permutation mode, tag pass-through and range checking.
module qsn_controller_pipe #(
  parameter int PERMUTATION_LENGTH = 7,
  parameter int SHIFT_W            = $clog2(PERMUTATION_LENGTH),
  parameter int TAG_W              = 4
) (
  input  logic                          sys_clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SHIFT_W-1:0]            shift_factor,
  input  logic                          in_reverse,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SHIFT_W-1:0]            left_sel,
  output logic [SHIFT_W-1:0]            right_sel,
  output logic [PERMUTATION_LENGTH-2:0] merge_sel,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_err,
  output logic                          err_sticky,
  input  logic                          err_clr
);

  localparam int Z  = PERMUTATION_LENGTH;
  localparam int AW = SHIFT_W + 1;
  localparam logic [SHIFT_W:0]   Z_W = AW'(Z);
  // Z - x fits in SHIFT_W bits for every x in 1..Z-1, so modular SHIFT_W-bit math is exact.
  localparam logic [SHIFT_W-1:0] Z_S = SHIFT_W'(Z);

  // Handshake: a word moves across a port in any cycle where valid and ready are both 1;
  // a stalled output (out_valid=1, out_ready=0) holds every output field stable.
  logic               w_s2_en;
  logic               w_s1_en;
  logic               w_in_xfer;
  logic               w_range;
  logic [SHIFT_W-1:0] w_seff;
  logic [SHIFT_W-1:0] w_left;
  logic [SHIFT_W-1:0] w_right;
  logic [Z-2:0]       w_merge;

  logic               r_s1_valid;
  logic [SHIFT_W-1:0] r_s1_seff;
  logic               r_s1_range;
  logic [TAG_W-1:0]   r_s1_tag;

  logic               r_out_valid;
  logic [SHIFT_W-1:0] r_left;
  logic [SHIFT_W-1:0] r_right;
  logic [Z-2:0]       r_merge;
  logic [TAG_W-1:0]   r_tag;
  logic               r_err;
  logic               r_err_sticky;

  assign w_s2_en   = !r_out_valid || out_ready;
  assign w_s1_en   = !r_s1_valid || w_s2_en;
  assign in_ready  = w_s1_en;
  assign w_in_xfer = in_valid && w_s1_en;
  assign w_range   = ({1'b0, shift_factor} >= Z_W);

  always_comb begin
    w_seff = '0;
    if (!w_range && (shift_factor != '0))
      w_seff = in_reverse ? (Z_S - shift_factor) : shift_factor;
  end

  // Lane i takes the left shifter when i < Z - s_eff, i.e. i + s_eff < Z.
  always_comb begin
    w_left  = '0;
    w_right = '0;
    w_merge = '0;
    if (r_s1_seff != '0) begin
      w_left  = r_s1_seff;
      w_right = Z_S - r_s1_seff;
      for (int i = 0; i < Z - 1; i++)
        w_merge[i] = ((AW'(i) + {1'b0, r_s1_seff}) < Z_W);
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_seff  <= '0;
      r_s1_range <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_seff  <= w_seff;
        r_s1_range <= w_range;
        r_s1_tag   <= in_tag;
      end
    end
  end

  // Bubbles clear out_valid but leave the select words at their last values.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_left      <= '0;
      r_right     <= '0;
      r_merge     <= '0;
      r_tag       <= '0;
      r_err       <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_left  <= w_left;
        r_right <= w_right;
        r_merge <= w_merge;
        r_tag   <= r_s1_tag;
        r_err   <= r_s1_range;
      end
    end
  end

  // A new range error takes priority over a simultaneous clear.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)
      r_err_sticky <= 1'b0;
    else if (w_in_xfer && w_range)
      r_err_sticky <= 1'b1;
    else if (err_clr)
      r_err_sticky <= 1'b0;
  end

  assign out_valid  = r_out_valid;
  assign left_sel   = r_left;
  assign right_sel  = r_right;
  assign merge_sel  = r_merge;
  assign out_tag    = r_tag;
  assign out_err    = r_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_qsn_controller_pipe.sv
// Directed bench for qsn_controller_pipe: a Z=7 instance for the main scenarios and a
// Z=3 instance checked against the legacy length-3 select table.
module tb_qsn_controller_pipe;

  localparam int SW  = 3;
  localparam int SW3 = 2;
  localparam int TW  = 4;

  logic          sys_clk = 1'b0;
  logic          rstn    = 1'b0;

  logic          in_valid = 1'b0, in_reverse = 1'b0, out_ready = 1'b1, err_clr = 1'b0;
  logic [SW-1:0] shift_factor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid, out_err, err_sticky;
  logic [SW-1:0] left_sel, right_sel;
  logic [5:0]    merge_sel;
  logic [TW-1:0] out_tag;

  logic           in_valid3 = 1'b0, in_reverse3 = 1'b0, out_ready3 = 1'b1, err_clr3 = 1'b0;
  logic [SW3-1:0] shift_factor3 = '0;
  logic [TW-1:0]  in_tag3 = '0;
  logic           in_ready3, out_valid3, out_err3, err_sticky3;
  logic [SW3-1:0] left_sel3, right_sel3;
  logic [1:0]     merge_sel3;
  logic [TW-1:0]  out_tag3;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  qsn_controller_pipe #(.PERMUTATION_LENGTH(7), .TAG_W(TW)) u_dut (
    .sys_clk(sys_clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .shift_factor(shift_factor), .in_reverse(in_reverse), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .left_sel(left_sel),
    .right_sel(right_sel), .merge_sel(merge_sel), .out_tag(out_tag),
    .out_err(out_err), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  qsn_controller_pipe #(.PERMUTATION_LENGTH(3), .TAG_W(TW)) u_dut3 (
    .sys_clk(sys_clk), .rstn(rstn), .in_valid(in_valid3), .in_ready(in_ready3),
    .shift_factor(shift_factor3), .in_reverse(in_reverse3), .in_tag(in_tag3),
    .out_valid(out_valid3), .out_ready(out_ready3), .left_sel(left_sel3),
    .right_sel(right_sel3), .merge_sel(merge_sel3), .out_tag(out_tag3),
    .out_err(out_err3), .err_sticky(err_sticky3), .err_clr(err_clr3)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_one(input logic [SW-1:0] s, input logic rev, input logic [TW-1:0] tag);
    in_valid = 1'b1; shift_factor = s; in_reverse = rev; in_tag = tag;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic drive_one3(input logic [SW3-1:0] s, input logic [TW-1:0] tag);
    in_valid3 = 1'b1; shift_factor3 = s; in_reverse3 = 1'b0; in_tag3 = tag;
    tick();
    in_valid3 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (left_sel !== 3'd0 || right_sel !== 3'd0 || merge_sel !== 6'd0) begin
      failures++; $display("FAIL rst_sels got=%0d/%0d/%b exp=0/0/000000", left_sel, right_sel, merge_sel); end
    checks++; if (out_tag !== 4'd0 || out_err !== 1'b0 || err_sticky !== 1'b0) begin
      failures++; $display("FAIL rst_tag_err got=%0d/%b/%b exp=0/0/0", out_tag, out_err, err_sticky); end
    checks++; if (out_valid3 !== 1'b0) begin failures++; $display("FAIL rst_out_valid3 got=%b exp=0", out_valid3); end
    rstn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_forward();
    logic [SW-1:0] t_s [4] = '{3'd2, 3'd6, 3'd0, 3'd1};
    logic [SW-1:0] t_l [4] = '{3'd2, 3'd6, 3'd0, 3'd1};
    logic [SW-1:0] t_r [4] = '{3'd5, 3'd1, 3'd0, 3'd6};
    logic [5:0]    t_m [4] = '{6'b011111, 6'b000001, 6'b000000, 6'b111111};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; shift_factor = t_s[i]; in_reverse = 1'b0; in_tag = 4'(i + 3);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_latency%0d out_valid got=%b exp=0", i, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'(i + 3) || out_err !== 1'b0) begin
        failures++; $display("FAIL fwd_ctl%0d got v=%b tag=%0d err=%b exp v=1 tag=%0d err=0", i, out_valid, out_tag, out_err, i + 3); end
      checks++; if (left_sel !== t_l[i] || right_sel !== t_r[i] || merge_sel !== t_m[i]) begin
        failures++; $display("FAIL fwd_sel%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, left_sel, right_sel, merge_sel, t_l[i], t_r[i], t_m[i]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0 || left_sel !== 3'd1 || right_sel !== 3'd6 || merge_sel !== 6'b111111) begin
      failures++; $display("FAIL fwd_bubble_retain got v=%b %0d/%0d/%b exp v=0 1/6/111111", out_valid, left_sel, right_sel, merge_sel); end
  endtask

  task automatic test_reverse();
    logic [SW-1:0] t_s [4] = '{3'd2, 3'd0, 3'd6, 3'd3};
    logic [SW-1:0] t_l [4] = '{3'd5, 3'd0, 3'd1, 3'd4};
    logic [SW-1:0] t_r [4] = '{3'd2, 3'd0, 3'd6, 3'd3};
    logic [5:0]    t_m [4] = '{6'b000011, 6'b000000, 6'b111111, 6'b000111};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_one(t_s[i], 1'b1, 4'(8 + i));
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'(8 + i) || out_err !== 1'b0) begin
        failures++; $display("FAIL rev_ctl%0d got v=%b tag=%0d err=%b exp v=1 tag=%0d err=0", i, out_valid, out_tag, out_err, 8 + i); end
      checks++; if (left_sel !== t_l[i] || right_sel !== t_r[i] || merge_sel !== t_m[i]) begin
        failures++; $display("FAIL rev_sel%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, left_sel, right_sel, merge_sel, t_l[i], t_r[i], t_m[i]); end
    end
  endtask

  task automatic test_range();
    out_ready = 1'b1;
    in_valid = 1'b1; shift_factor = 3'd7; in_reverse = 1'b0; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL range_sticky_set got=%b exp=1", err_sticky); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_tag !== 4'd9) begin
      failures++; $display("FAIL range_out got v=%b err=%b tag=%0d exp v=1 err=1 tag=9", out_valid, out_err, out_tag); end
    checks++; if (left_sel !== 3'd0 || right_sel !== 3'd0 || merge_sel !== 6'd0) begin
      failures++; $display("FAIL range_sels got=%0d/%0d/%b exp=0/0/000000", left_sel, right_sel, merge_sel); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL range_sticky_hold got=%b exp=1", err_sticky); end
    in_valid = 1'b1; shift_factor = 3'd7; in_reverse = 1'b1; in_tag = 4'd10; err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL range_set_beats_clr got=%b exp=1", err_sticky); end
    tick();
    checks++; if (out_err !== 1'b1 || left_sel !== 3'd0 || out_tag !== 4'd10) begin
      failures++; $display("FAIL range_rev_out got err=%b left=%0d tag=%0d exp err=1 left=0 tag=10", out_err, left_sel, out_tag); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL range_clr got=%b exp=0", err_sticky); end
    tick();
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL range_clr_hold got=%b exp=0", err_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] t_r [6] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    logic [5:0]    t_m [6] = '{6'b111111, 6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001};
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] e;
    logic [SW-1:0] h_l, h_r;
    logic [5:0]    h_m;
    logic [TW-1:0] h_t;
    logic          hold_pending = 1'b0;
    logic          saw_low = 1'b0;
    int            sent = 0;
    int            received = 0;
    int            idx;
    for (int c = 0; c < 40 && received < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 6);
      shift_factor = 3'(sent + 1); in_reverse = 1'b0; in_tag = 4'(sent + 1);
      #1;
      if (hold_pending) begin
        checks++; if (out_valid !== 1'b1 || left_sel !== h_l || right_sel !== h_r || merge_sel !== h_m || out_tag !== h_t) begin
          failures++; $display("FAIL b2b_hold c=%0d got v=%b %0d/%0d/%b tag=%0d exp v=1 %0d/%0d/%b tag=%0d",
                               c, out_valid, left_sel, right_sel, merge_sel, out_tag, h_l, h_r, h_m, h_t); end
      end
      hold_pending = out_valid && !out_ready;
      h_l = left_sel; h_r = right_sel; h_m = merge_sel; h_t = out_tag;
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_output tag=%0d exp none", out_tag);
        end else begin
          e = exp_q.pop_front();
          idx = int'(e) - 1;
          if (out_tag !== e || left_sel !== 3'(e) || right_sel !== t_r[idx] || merge_sel !== t_m[idx] || out_err !== 1'b0) begin
            failures++; $display("FAIL b2b_out got tag=%0d %0d/%0d/%b err=%b exp tag=%0d %0d/%0d/%b err=0",
                                 out_tag, left_sel, right_sel, merge_sel, out_err, e, e, t_r[idx], t_m[idx]); end
        end
        received++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_tag);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (received != 6 || sent != 6) begin failures++; $display("FAIL b2b_count got sent=%0d recv=%0d exp 6/6", sent, received); end
    checks++; if (saw_low !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_drop got=%b exp=1", saw_low); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; shift_factor = 3'd3; in_reverse = 1'b0; in_tag = 4'd1;
    tick();
    shift_factor = 3'd7; in_tag = 4'd2;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || left_sel !== 3'd3 || out_tag !== 4'd1 || err_sticky !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_pre got v=%b left=%0d tag=%0d sticky=%b rdy=%b exp 1/3/1/1/0",
                           out_valid, left_sel, out_tag, err_sticky, in_ready); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || left_sel !== 3'd0 || right_sel !== 3'd0 || merge_sel !== 6'd0) begin
      failures++; $display("FAIL mid_rst_sels got v=%b %0d/%0d/%b exp 0 0/0/000000", out_valid, left_sel, right_sel, merge_sel); end
    checks++; if (out_tag !== 4'd0 || out_err !== 1'b0 || err_sticky !== 1'b0) begin
      failures++; $display("FAIL mid_rst_flags got tag=%0d err=%b sticky=%b exp 0/0/0", out_tag, out_err, err_sticky); end
    tick();
    rstn = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d out_valid got=%b exp=0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_z3();
    logic [SW3-1:0] t_r [3] = '{2'd0, 2'd2, 2'd1};
    logic [1:0]     t_m [3] = '{2'b00, 2'b11, 2'b01};
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_one3(2'(i), 4'(i + 1));
      checks++; if (out_valid3 !== 1'b1 || left_sel3 !== 2'(i) || right_sel3 !== t_r[i] || merge_sel3 !== t_m[i] || out_tag3 !== 4'(i + 1)) begin
        failures++; $display("FAIL z3_s%0d got v=%b %0d/%0d/%b tag=%0d exp v=1 %0d/%0d/%b tag=%0d",
                             i, out_valid3, left_sel3, right_sel3, merge_sel3, out_tag3, i, t_r[i], t_m[i], i + 1); end
    end
    drive_one3(2'd3, 4'd7);
    checks++; if (out_err3 !== 1'b1 || left_sel3 !== 2'd0 || merge_sel3 !== 2'b00 || err_sticky3 !== 1'b1) begin
      failures++; $display("FAIL z3_range got err=%b left=%0d merge=%b sticky=%b exp 1/0/00/1", out_err3, left_sel3, merge_sel3, err_sticky3); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_range();
    test_back_to_back();
    test_reset_midflight();
    test_z3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
